// File: rtl/instr_cache_responder.sv
`timescale 1ns/1ps
// Direct-mapped, read-only instruction cache: zero-latency hits, whole-line refill
// from a slow 128-bit memory over a read/busywait handshake on a miss.
module instr_cache_responder #(
    parameter int ADDR_WIDTH      = 10,
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                              CLK,
    input  logic                                              RESET,
    input  logic [31:0]                                       PC,
    output logic [31:0]                                       INSTRUCTION,
    output logic                                              BUSYWAIT,
    output logic                                              MEM_READ,
    output logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK)-3:0]     MEM_ADDRESS,
    input  logic [32*WORDS_PER_BLOCK-1:0]                     MEM_READDATA,
    input  logic                                              MEM_BUSYWAIT,
    output logic [CNT_WIDTH-1:0]                              MISS_COUNT
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int LA_W  = TAG_W + IDX_W;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef logic [WORDS_PER_BLOCK-1:0][31:0] line_t;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [LA_W-1:0]        addr_q, addr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:0]            instr_q, instr_d;
    logic [NUM_BLOCKS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_BLOCKS];
    line_t                  data_q [NUM_BLOCKS];

    logic [TAG_W-1:0]       pc_tag;
    logic [IDX_W-1:0]       pc_idx;
    logic [OFF_W-1:0]       pc_off;
    logic [IDX_W-1:0]       fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    logic                   hit;
    logic                   fill_en;
    logic                   busy;
    logic                   mem_read;
    logic [31:0]            instr_out;
    logic                   unused_pc;

    assign pc_tag    = PC[ADDR_WIDTH-1 -: TAG_W];
    assign pc_idx    = PC[OFF_W+2 +: IDX_W];
    assign pc_off    = PC[2 +: OFF_W];
    assign unused_pc = ^{PC[31:ADDR_WIDTH], PC[1:0]};

    assign fill_idx  = addr_q[IDX_W-1:0];
    assign fill_tag  = addr_q[LA_W-1:IDX_W];
    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        fill_en   = 1'b0;
        busy      = 1'b0;
        mem_read  = 1'b0;
        instr_out = instr_q;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    instr_out = data_q[pc_idx][pc_off];
                    instr_d   = data_q[pc_idx][pc_off];
                end else begin
                    busy    = 1'b1;
                    state_d = S_REQ;
                    addr_d  = {pc_tag, pc_idx};
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_REQ: begin
                // Wait for memory to acknowledge by raising busywait.
                busy     = 1'b1;
                mem_read = 1'b1;
                if (MEM_BUSYWAIT) state_d = S_WAIT;
            end
            S_WAIT: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    fill_en           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            data_q[fill_idx] <= MEM_READDATA;
            tag_q[fill_idx]  <= fill_tag;
        end
    end

    assign BUSYWAIT    = RESET & busy;
    assign INSTRUCTION = instr_out;
    assign MEM_READ    = mem_read;
    assign MEM_ADDRESS = addr_q;
    assign MISS_COUNT  = cnt_q;

endmodule

// File: tb/tb_instr_cache_responder.sv
`timescale 1ns/1ps
// Directed bench for instr_cache_responder: cold miss, hits, eviction, handshake
// delay, reset mid-fill and counter saturation (narrow-counter second instance).
module tb_instr_cache_responder;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    logic [31:0]  INSTRUCTION, INSTRUCTION_s;
    logic         BUSYWAIT, BUSYWAIT_s;
    logic         MEM_READ, MEM_READ_s;
    logic [5:0]   MEM_ADDRESS, MEM_ADDRESS_s;
    logic [15:0]  MISS_COUNT;
    logic [3:0]   MISS_COUNT_s;

    int n_tests = 0;
    int n_fail  = 0;
    int stall;
    int cnt;
    int sat_exp;

    logic [127:0] line0;
    logic [127:0] line1;

    always #5 CLK = ~CLK;

    instr_cache_responder #(.CNT_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .MISS_COUNT(MISS_COUNT)
    );

    instr_cache_responder #(.CNT_WIDTH(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION_s),
        .BUSYWAIT(BUSYWAIT_s), .MEM_READ(MEM_READ_s), .MEM_ADDRESS(MEM_ADDRESS_s),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT), .MISS_COUNT(MISS_COUNT_s)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: MEM_BUSYWAIT high for nb cycles starting ad cycles after the
    // request cycle, then the line is presented as busywait falls.
    task automatic fill(input logic [127:0] line, input int ad, input int nb, output int stl);
        int k;
        stl = 0;
        k   = 0;
        while (BUSYWAIT === 1'b1 && k < 100) begin
            stl++;
            tick();
            k++;
            MEM_BUSYWAIT = (k >= 1 + ad) && (k <= ad + nb);
            MEM_READDATA = (k == ad + nb + 1) ? line : ~line;
            settle();
        end
        MEM_BUSYWAIT = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        line0 = 128'h44444444_33333333_22222222_11111111;
        line1 = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
        RESET = 1'b0;
        PC = 32'h0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;

        tick(); tick(); settle();
        chk("rst_busywait", BUSYWAIT, 0);
        chk("rst_instr", INSTRUCTION, 0);
        chk("rst_mem_read", MEM_READ, 0);
        chk("rst_mem_addr", MEM_ADDRESS, 0);
        chk("rst_miss_count", MISS_COUNT, 0);

        // Cold miss on line 0
        tick(); RESET = 1'b1; settle();
        chk("cold_busy", BUSYWAIT, 1);
        chk("cold_instr_held", INSTRUCTION, 0);
        fill(line0, 0, 5, stall);
        chk("cold_stall", stall, 7);
        chk("cold_instr", INSTRUCTION, 32'h11111111);
        chk("cold_mem_addr", MEM_ADDRESS, 0);
        chk("cold_miss_count", MISS_COUNT, 1);
        chk("cold_mem_read_low", MEM_READ, 0);

        for (int i = 1; i < 4; i++) begin
            tick(); PC = 32'(i * 4); settle();
            chk("seq_instr", INSTRUCTION, line0[i*32 +: 32]);
            chk("seq_busy", BUSYWAIT, 0);
            chk("seq_mem_read", MEM_READ, 0);
        end

        // Conflict: index 0, tag 1 evicts line 0
        tick(); PC = 32'h080; settle();
        chk("conf_busy", BUSYWAIT, 1);
        chk("conf_instr_held", INSTRUCTION, 32'h44444444);
        fill(line1, 0, 2, stall);
        chk("conf_stall", stall, 4);
        chk("conf_mem_addr", MEM_ADDRESS, 6'h08);
        chk("conf_instr", INSTRUCTION, 32'haaaaaaaa);
        chk("conf_miss_count", MISS_COUNT, 2);

        // Re-miss on 0x000 with a 3-cycle acknowledge delay
        tick(); PC = 32'h000; settle();
        chk("evict_busy", BUSYWAIT, 1);
        fill(line0, 3, 1, stall);
        chk("ack_delay_stall", stall, 6);
        chk("ack_delay_instr", INSTRUCTION, 32'h11111111);
        chk("ack_delay_miss_count", MISS_COUNT, 3);

        // Upper PC bits and byte offset are ignored
        tick(); PC = 32'h40F; settle();
        chk("alias_instr", INSTRUCTION, 32'h44444444);
        chk("alias_busy", BUSYWAIT, 0);

        // Reset while waiting for the line
        tick(); PC = 32'h010; settle();
        chk("rmid_busy", BUSYWAIT, 1);
        tick(); MEM_BUSYWAIT = 1'b1; settle();
        chk("rmid_req_read", MEM_READ, 1);
        chk("rmid_req_addr", MEM_ADDRESS, 6'h01);
        tick(); settle();
        chk("rmid_wait_read", MEM_READ, 1);
        RESET = 1'b0; settle();
        chk("rmid_read_drop", MEM_READ, 0);
        chk("rmid_busy_drop", BUSYWAIT, 0);
        chk("rmid_count_clr", MISS_COUNT, 0);
        chk("rmid_addr_clr", MEM_ADDRESS, 0);
        tick(); MEM_BUSYWAIT = 1'b0; MEM_READDATA = line1;
        tick(); tick();
        RESET = 1'b1; PC = 32'h000; settle();
        chk("post_rst_busy", BUSYWAIT, 1);
        fill(line0, 0, 1, stall);
        chk("post_rst_stall", stall, 3);
        chk("post_rst_count", MISS_COUNT, 1);
        chk("post_rst_instr", INSTRUCTION, 32'h11111111);
        tick(); PC = 32'h010; settle();
        chk("late_fall_ignored", BUSYWAIT, 1);
        fill(line1, 0, 1, stall);
        chk("late_fill_instr", INSTRUCTION, 32'haaaaaaaa);
        chk("late_fill_count", MISS_COUNT, 2);

        // Alternate conflicting lines to drive the counters
        for (int j = 0; j < 20; j++) begin
            tick(); PC = (j % 2 == 0) ? 32'h080 : 32'h000; settle();
            chk("sat_busy", BUSYWAIT, 1);
            fill((j % 2 == 0) ? line1 : line0, 0, 1, stall);
            cnt = 3 + j;
            sat_exp = (cnt > 15) ? 15 : cnt;
            chk("sat_main_count", MISS_COUNT, cnt);
            chk("sat_narrow_count", MISS_COUNT_s, sat_exp);
        end
        chk("sat_final_narrow", MISS_COUNT_s, 4'hF);
        chk("sat_final_instr", INSTRUCTION, 32'h11111111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cache_responder.md
Name: instr_cache_responder

Overview:
Direct-mapped instruction cache that answers CPU instruction fetches. It sits between the CPU's PC/INSTRUCTION fetch port and a slow 128-bit-line instruction memory. On a hit it returns the 32-bit word in the same cycle. On a miss it stalls the CPU with BUSYWAIT, fetches the whole line from memory over a read/busywait handshake, fills the line, then serves the fetch as a hit.

Parameters:
ADDR_WIDTH, 10, byte-address bits used from PC (1 KiB instruction space)
NUM_BLOCKS, 8, cache lines; index width = log2(NUM_BLOCKS) = 3
WORDS_PER_BLOCK, 4, 32-bit words per line; line = 128 bits; offset = PC[3:2]
CNT_WIDTH, 16, width of saturating miss counter

Ports:
CLK  in  1  system clock; all state updates on posedge
RESET  in  1  asynchronous, active-low reset (0 = reset asserted)
PC  in  32  CPU fetch byte address; only PC[9:0] used; PC[1:0] ignored
INSTRUCTION  out  32  fetched instruction word; valid when BUSYWAIT=0
BUSYWAIT  out  1  1 = CPU must stall and hold PC
MEM_READ  out  1  line read request to instruction memory
MEM_ADDRESS  out  6  line address {tag, index} = PC[9:4] of the latched miss
MEM_READDATA  in  128  line data; word n = MEM_READDATA[32n+31:32n]
MEM_BUSYWAIT  in  1  memory busy; a 1->0 transition while MEM_READ=1 means MEM_READDATA is valid
MISS_COUNT  out  CNT_WIDTH  number of misses since reset; saturates at all-ones

Behaviour:
- Address split: tag = PC[9:7], index = PC[6:4], word offset = PC[3:2].
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- Reset (RESET=0, asynchronous):
  - all valid bits clear; state IDLE; MEM_READ=0; MEM_ADDRESS=0; MISS_COUNT=0.
  - BUSYWAIT=0 and INSTRUCTION=0 while reset is held.
  - Data and tag arrays are not cleared.
- Hit = valid[index] && tag[index]==tag. This is combinational from PC and the arrays.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Hit: INSTRUCTION = word[offset] of the line, BUSYWAIT=0, same cycle (zero-cycle latency).
  - Miss: BUSYWAIT=1 combinationally. At the next edge: latch PC[9:4] into MEM_ADDRESS, go to REQ, increment MISS_COUNT (saturating).
- REQ:
  - MEM_READ=1, BUSYWAIT=1.
  - On an edge where MEM_BUSYWAIT=1, go to WAIT.
  - Otherwise stay in REQ: the memory has not yet acknowledged the request.
- WAIT:
  - MEM_READ=1, BUSYWAIT=1.
  - On an edge where MEM_BUSYWAIT=0: write MEM_READDATA into data[latched index], write the tag, set valid, drop MEM_READ, go to IDLE.
- After a fill, the IDLE re-evaluation hits. BUSYWAIT falls in the cycle after the fill edge.
- Miss penalty = 2 + N cycles, where N = cycles MEM_BUSYWAIT is held high. Minimum 3 cycles from miss detection to BUSYWAIT=0.
- INSTRUCTION holds its last hit value while BUSYWAIT=1 (X is not allowed).
- The CPU must hold PC while BUSYWAIT=1. The fill always uses the latched MEM_ADDRESS, never a PC that changes mid-miss. On return to IDLE the current PC is re-evaluated; a differing PC may start a new miss.
- Conflict miss (same index, different tag): the line is overwritten. There is no write-back because the cache is read-only.
- Reset during REQ/WAIT:
  - immediately IDLE, MEM_READ=0, all lines invalid; the pending fill is discarded.
  - A late MEM_BUSYWAIT fall after reset has no effect.
- PC wrap: PC[31:10] is ignored, so PC=0x400 aliases PC=0x000.
- MISS_COUNT stays at 0xFFFF once reached; it does not roll over.

Test Plan:
- Cold miss: release reset; PC=0x000; memory holds busywait for 5 cycles, then returns line 0x44444444_33333333_22222222_11111111 -> BUSYWAIT=1 for 7 cycles, MEM_ADDRESS=0, INSTRUCTION=0x11111111, MISS_COUNT=1.
- Sequential hits: after the cold miss, PC=0x004, 0x008, 0x00C on consecutive cycles -> INSTRUCTION=0x22222222, 0x33333333, 0x44444444 with BUSYWAIT=0 and MEM_READ=0 throughout.
- Conflict eviction: fill PC=0x080 (index 0, tag 1) -> MEM_ADDRESS=0x08. A later PC=0x000 misses again, MISS_COUNT=3.
- Handshake ack delay: MEM_BUSYWAIT stays 0 for 3 cycles after MEM_READ rises -> FSM stays in REQ and no fill occurs. The fill completes only after a 1->0 on MEM_BUSYWAIT.
- Reset mid-fill: assert RESET=0 during WAIT -> MEM_READ=0 and BUSYWAIT=0 immediately. After release, PC=0x000 misses again (valid cleared) and MISS_COUNT restarts at 1.
- Saturation: force 65537 misses by alternating PC 0x000/0x080 -> MISS_COUNT=0xFFFF.
